// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH   : default operand / quotient / remainder width
//   DIV_CNT_W   : iteration counter width for the default width
//   div_state_t : divider control states
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step. The partial remainder and the
// dividend/quotient shift register are shifted left one place together; the
// dividend MSB moves into the remainder and the new quotient bit enters at the
// LSB of the quotient.
// Ports:
//   rem_in  [WIDTH:0]   partial remainder before the step
//   quo_in  [WIDTH-1:0] remaining dividend bits / quotient bits so far
//   divisor [WIDTH-1:0] divisor magnitude
//   rem_out [WIDTH:0]   partial remainder after the step
//   quo_out [WIDTH-1:0] shifted register with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;

    // Trial subtraction one bit wider than the shifted remainder so the
    // borrow (bit WIDTH+1) cleanly signals a negative result.
    always_comb begin
        w_shift = {rem_in, quo_in[WIDTH-1]};
        w_trial = w_shift - {2'b00, divisor};
        if (w_trial[WIDTH+1] == 1'b0) begin
            rem_out = w_trial[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = w_shift[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule : div_step

// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
// Sequential restoring divider, one quotient bit per clock, sharing the
// start/ready handshake of the shift-add multiplier.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin (level; held high restarts each edge)
//   A, B         dividend, divisor
//   Quotient     quotient  (LO)
//   Remainder    remainder (HI)
//   ready        1 = idle/done, results valid and held
//   div_by_zero  1 = last division had B == 0
//   is_signed    only with SIGNED_DIV_EN: 1 = DIV, 0 = DIVU
// Configuration macro: SIGNED_DIV_EN adds signed division and a FIXUP state
// (fixed latency WIDTH+1); without it the latency is exactly WIDTH edges.
// -----------------------------------------------------------------------------
module divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             ready,
    output logic             div_by_zero
);

    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_ready;
    logic             r_dbz;

    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_b_zero;

`ifdef SIGNED_DIV_EN
    logic             r_neg_q;
    logic             r_neg_r;
    logic             w_neg_a;
    logic             w_neg_b;

    // Signed operands are reduced to magnitudes; the signs drive the fixup.
    always_comb begin
        w_neg_a = is_signed & A[WIDTH-1];
        w_neg_b = is_signed & B[WIDTH-1];
        if (w_neg_a) begin
            w_op_a = ~A + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_op_a = A;
        end
        if (w_neg_b) begin
            w_op_b = ~B + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_op_b = B;
        end
    end
`else
    // Unsigned build: operands pass straight through.
    always_comb begin
        w_op_a = A;
        w_op_b = B;
    end
`endif

    assign w_b_zero = (B == {WIDTH{1'b0}});

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_div),
        .rem_out (w_rem_nxt),
        .quo_out (w_quo_nxt)
    );

    // Control FSM and datapath registers; start takes priority in every state,
    // which also gives the abort/restart behaviour while BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_rem   <= {(WIDTH+1){1'b0}};
            r_quo   <= {WIDTH{1'b0}};
            r_div   <= {WIDTH{1'b0}};
            r_ready <= 1'b1;
            r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else if (start) begin
            r_cnt <= {CNT_W{1'b0}};
            if (w_b_zero) begin
                // Divide by zero completes in the start edge itself.
                r_state <= DONE;
                r_quo   <= {WIDTH{1'b1}};
                r_rem   <= {1'b0, A};
                r_div   <= {WIDTH{1'b0}};
                r_ready <= 1'b1;
                r_dbz   <= 1'b1;
`ifdef SIGNED_DIV_EN
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
`endif
            end else begin
                r_state <= BUSY;
                r_quo   <= w_op_a;
                r_rem   <= {(WIDTH+1){1'b0}};
                r_div   <= w_op_b;
                r_ready <= 1'b0;
                r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
                r_neg_q <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_neg_a;
`endif
            end
        end else begin
            case (r_state)
                BUSY: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_cnt == LAST) begin
`ifdef SIGNED_DIV_EN
                        r_state <= FIXUP;
`else
                        r_state <= DONE;
                        r_ready <= 1'b1;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                FIXUP: begin
                    // Truncate toward zero: quotient takes the XOR of the
                    // signs, remainder takes the dividend's sign.
                    if (r_neg_q) begin
                        r_quo <= ~r_quo + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (r_neg_r) begin
                        r_rem <= {1'b0, ~r_rem[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}};
                    end
                    r_state <= DONE;
                    r_ready <= 1'b1;
                end
`endif
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign Quotient    = r_quo;
    assign Remainder   = r_rem[WIDTH-1:0];
    assign ready       = r_ready;
    assign div_by_zero = r_dbz;

endmodule : divider_seq

// File: tb/tb_divider_seq.sv
module tb_divider_seq;

    localparam int W = 32;
`ifdef SIGNED_DIV_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         ready;
    logic         div_by_zero;
`ifdef SIGNED_DIV_EN
    logic         is_signed;
`endif

    int n_vec = 0;
    int n_err = 0;

    divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
`ifdef SIGNED_DIV_EN
        .is_signed   (is_signed),
`endif
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .ready       (ready),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero when signed.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
            dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // Wait for ready starting from the negedge after E0; returns edges counted.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic apply_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        start = 1'b1; A = a; B = b;
`ifdef SIGNED_DIV_EN
        is_signed = sgn;
`else
        if (sgn) $display("note: signed request ignored in unsigned build");
`endif
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        logic [W-1:0] eq, er;
        bit edz;
        model(a, b, sgn, eq, er, edz);
        n_vec++;
        if (Quotient !== eq) begin
            n_err++; $display("FAIL %s quotient: got %h want %h (A=%h B=%h)", tag, Quotient, eq, a, b);
        end
        n_vec++;
        if (Remainder !== er) begin
            n_err++; $display("FAIL %s remainder: got %h want %h (A=%h B=%h)", tag, Remainder, er, a, b);
        end
        n_vec++;
        if (div_by_zero !== edz) begin
            n_err++; $display("FAIL %s div_by_zero: got %b want %b", tag, div_by_zero, edz);
        end
    endtask

    // Full division: one-cycle start pulse, latency check, result check.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        int n;
        @(negedge clk);
        apply_start(a, b, sgn);
        @(negedge clk);
        start = 1'b0;
        if (b != 0) begin
            n_vec++;
            if (ready !== 1'b0) begin
                n_err++; $display("FAIL %s ready_low_after_start: got %b want 0", tag, ready);
            end
            wait_ready(n);
            n_vec++;
            if (n != LAT) begin
                n_err++; $display("FAIL %s latency: got %0d edges want %0d", tag, n, LAT);
            end
        end else begin
            n_vec++;
            if (ready !== 1'b1) begin
                n_err++; $display("FAIL %s ready_dbz: got %b want 1", tag, ready);
            end
        end
        check_result(tag, a, b, sgn);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
`ifdef SIGNED_DIV_EN
        is_signed = 1'b0;
`endif
        #12;
        n_vec++;
        if (Quotient !== '0 || Remainder !== '0 || ready !== 1'b1 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got Q=%h R=%h rdy=%b dz=%b want 0 0 1 0",
                     Quotient, Remainder, ready, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_div("d100_7", 32'd100, 32'd7, 1'b0);
        run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div("d5_msb", 32'd5, 32'h8000_0000, 1'b0);
        run_div("dmax_msb", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run_div("d0_3", 32'd0, 32'd3, 1'b0);
        run_div("d7_7", 32'd7, 32'd7, 1'b0);
    endtask

    task automatic test_div_zero();
        run_div("dbz", 32'h1234, 32'd0, 1'b0);
        run_div("dbz_clear", 32'd50, 32'd6, 1'b0);
    endtask

    task automatic test_hold();
        logic [W-1:0] eq, er;
        bit edz;
        model(32'd1000, 32'd33, 1'b0, eq, er, edz);
        run_div("hold", 32'd1000, 32'd33, 1'b0);
        A = 32'hDEAD_BEEF; B = 32'd3;
        repeat (4) @(negedge clk);
        n_vec++;
        if (Quotient !== eq || Remainder !== er || ready !== 1'b1) begin
            n_err++; $display("FAIL hold: got Q=%h R=%h rdy=%b want %h %h 1", Quotient, Remainder, ready, eq, er);
        end
    endtask

    task automatic test_abort();
        int n;
        @(negedge clk);
        apply_start(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL abort_busy: got ready %b want 0", ready);
        end
        apply_start(32'd9, 32'd3, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_ready(n);
        n_vec++;
        if (n != LAT) begin
            n_err++; $display("FAIL abort_latency: got %0d edges want %0d", n, LAT);
        end
        check_result("abort", 32'd9, 32'd3, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        apply_start(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (Quotient !== '0 || Remainder !== '0 || ready !== 1'b1 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got Q=%h R=%h rdy=%b dz=%b want 0 0 1 0",
                     Quotient, Remainder, ready, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_div("after_reset", 32'd81, 32'd9, 1'b0);
    endtask

    task automatic test_start_held();
        int n;
        @(negedge clk);
        apply_start(32'd11, 32'd2, 1'b0);
        @(negedge clk);
        apply_start(32'd77, 32'd4, 1'b0);
        @(negedge clk);
        apply_start(32'd500, 32'd9, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL held_ready_low: got %b want 0", ready);
        end
        wait_ready(n);
        n_vec++;
        if (n != LAT) begin
            n_err++; $display("FAIL held_latency: got %0d edges want %0d", n, LAT);
        end
        check_result("held", 32'd500, 32'd9, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        bit sgn;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) b = '0;
`ifdef SIGNED_DIV_EN
            sgn = ($urandom_range(0, 1) == 1);
`else
            sgn = 1'b0;
`endif
            run_div("random", a, b, sgn);
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("s_dbz", 32'hFFFF_FFF9, 32'd0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_hold();
        test_abort();
        test_async_reset();
        test_start_held();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_divider_seq
